poly_write_buffer: RTL

Sits directly downstream of the hash/sampler stage. Accepts 48-bit sample words (four 12-bit coefficients) with their 6-bit word address and valid strobe from the Parse/CBD path, buffers them in a small FIFO, and writes them into the polynomial SRAM through a request/grant port. Counts committed words, flags protocol and range errors, and signals completion of a full 256-coefficient polynomial (64 words).

---
 rtl/poly_write_buffer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/poly_write_buffer.sv
// Polynomial SRAM write buffer: queues sampler words in a small FIFO and drains
// them through a req/gnt port, counting commits until a full polynomial is written.
module poly_write_buffer #(
    parameter int DATA_W    = 48,
    parameter int ADDR_W    = 6,
    parameter int DEPTH     = 4,
    parameter int NUM_WORDS = 64,
    parameter int Q         = 3329
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [DATA_W-1:0]   in_sample,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic                in_valid,
    output logic                in_stall,
    output logic                sram_req,
    input  logic                sram_gnt,
    output logic                sram_we,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_wdata,
    output logic [ADDR_W:0]     word_count,
    output logic                poly_done,
    output logic                overflow,
    output logic                range_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LANE_W = 12;
    localparam int LANES = DATA_W / LANE_W;
    localparam logic [PTR_W:0] FULL_OCC = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] ONE_OCC = (PTR_W+1)'(1);
    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(NUM_WORDS - 1);
    localparam logic [LANE_W-1:0] Q_LANE = LANE_W'(Q);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t state, state_next;

    logic [ADDR_W+DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   occ;
    logic full, empty, push, pop, drop, last_commit, lane_bad;

    assign full  = (occ == FULL_OCC);
    assign empty = (occ == '0);
    assign pop   = sram_req && sram_gnt;
    // Full is judged on registered occupancy, so a same-cycle pop never frees a slot.
    assign push  = (state == ACTIVE) && !start && in_valid && !full;
    assign drop  = (state == ACTIVE) && !start && in_valid && full;
    assign last_commit = pop && (word_count == LAST_CNT);

    always_comb begin
        lane_bad = 1'b0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (in_sample[i*LANE_W +: LANE_W] >= Q_LANE) lane_bad = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (start) begin
            state_next = ACTIVE;
        end else begin
            case (state)
                ACTIVE:  if (last_commit) state_next = DONE;
                default: state_next = state;
            endcase
        end
    end

    always_comb begin
        sram_req   = (state == ACTIVE) && !empty;
        sram_we    = sram_req;
        sram_addr  = '0;
        sram_wdata = '0;
        if (sram_req) begin
            sram_addr  = mem[rd_ptr][ADDR_W+DATA_W-1:DATA_W];
            sram_wdata = mem[rd_ptr][DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_addr, in_sample};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            word_count <= '0;
            overflow   <= 1'b0;
            range_err  <= 1'b0;
            poly_done  <= 1'b0;
            in_stall   <= 1'b0;
        end else if (start) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            word_count <= '0;
            overflow   <= 1'b0;
            range_err  <= 1'b0;
            poly_done  <= 1'b0;
            in_stall   <= 1'b0;
        end else begin
            poly_done <= (state == DONE);
            if (pop) word_count <= word_count + 1'b1;
            if (drop) overflow <= 1'b1;
            if (push && lane_bad) range_err <= 1'b1;
            if (last_commit) begin
                // Anything still queued (or arriving now) belongs to no polynomial.
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                occ      <= '0;
                in_stall <= 1'b0;
                if (occ > ONE_OCC || push) overflow <= 1'b1;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10: begin
                        occ      <= occ + 1'b1;
                        in_stall <= (occ + 1'b1 == FULL_OCC);
                    end
                    2'b01: begin
                        occ      <= occ - 1'b1;
                        in_stall <= 1'b0;
                    end
                    default: in_stall <= full;
                endcase
            end
        end
    end
endmodule
